// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD1602 write-port arbiter.
// Contents: the word carried by each requester ({rs, data}), the arbiter
// state encoding and the default inter-command hold-off length.
package lcd_pkg;

  // Hold-off after each ctrl_Done, in system clock cycles.
  localparam logic [15:0] LCD_DELAY_DEFAULT = 16'hF6BE;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_word_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    HOLDOFF   = 2'd2
  } lcd_state_e;

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Bundle of the two requester channels plus the LCD_controller handshake.
// Ports (from the arbiter's point of view, modport slave):
//   iREQx_VALID/iREQx_DATA/iREQx_LOCK in, oREQx_READY out  (x = 0, 1)
//   oCTRL_START/oCTRL_RS/oCTRL_DATA out, iCTRL_DONE in
//   oGRANT (one-hot last owner) out, oBUSY out
// The master modport is the mirror image, used by whatever drives the block.
interface lcd_write_arbiter_if;
  logic       iREQ0_VALID;
  logic [8:0] iREQ0_DATA;
  logic       iREQ0_LOCK;
  logic       oREQ0_READY;
  logic       iREQ1_VALID;
  logic [8:0] iREQ1_DATA;
  logic       iREQ1_LOCK;
  logic       oREQ1_READY;
  logic       oCTRL_START;
  logic       oCTRL_RS;
  logic [7:0] oCTRL_DATA;
  logic       iCTRL_DONE;
  logic [1:0] oGRANT;
  logic       oBUSY;

  modport slave (
    input  iREQ0_VALID, iREQ0_DATA, iREQ0_LOCK,
    input  iREQ1_VALID, iREQ1_DATA, iREQ1_LOCK,
    input  iCTRL_DONE,
    output oREQ0_READY, oREQ1_READY,
    output oCTRL_START, oCTRL_RS, oCTRL_DATA,
    output oGRANT, oBUSY
  );

  modport master (
    output iREQ0_VALID, iREQ0_DATA, iREQ0_LOCK,
    output iREQ1_VALID, iREQ1_DATA, iREQ1_LOCK,
    output iCTRL_DONE,
    input  oREQ0_READY, oREQ1_READY,
    input  oCTRL_START, oCTRL_RS, oCTRL_DATA,
    input  oGRANT, oBUSY
  );
endinterface

// File: rtl/lcd_rr_arbiter.sv
// Two-input round-robin grant logic with an optional lock and lock timeout.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   idle_i         the write port is free; grants are only given while high
//   valid_i[1:0]   requester valid flags
//   lock_i[1:0]    requester lock flags (meaningful for the granted word)
//   grant_o[1:0]   one-hot grant, doubles as READY and as "word accepted"
module lcd_rr_arbiter #(
  parameter int unsigned LOCK_TO = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       idle_i,
  input  logic [1:0] valid_i,
  input  logic [1:0] lock_i,
  output logic [1:0] grant_o
);

  localparam int unsigned TW = $clog2(LOCK_TO + 1);

  logic          lastGnt_q, lastGnt_d;
  logic          lockOn_q, lockOn_d;
  logic          lockOwner_q, lockOwner_d;
  logic [TW-1:0] toCnt_q, toCnt_d;

  logic          ownerValid;
  logic          expired;
  logic          lockEff;
  logic          winIdx;

  assign ownerValid = valid_i[lockOwner_q];

  // The lock lapses in the cycle the counter sits at LOCK_TO, so the other
  // requester can already be granted in that very cycle.
  assign expired = lockOn_q && idle_i && !ownerValid && (toCnt_q == TW'(LOCK_TO));
  assign lockEff = lockOn_q && !expired;
  assign winIdx  = grant_o[1];

  always_comb begin
    grant_o = 2'b00;
    if (idle_i) begin
      if (lockEff) begin
        if (lockOwner_q) grant_o = {valid_i[1], 1'b0};
        else             grant_o = {1'b0, valid_i[0]};
      end else if (&valid_i) begin
        // Tie: the requester that was not granted last time wins.
        grant_o = lastGnt_q ? 2'b01 : 2'b10;
      end else begin
        grant_o = valid_i;
      end
    end
  end

  always_comb begin
    lastGnt_d   = lastGnt_q;
    lockOn_d    = lockOn_q;
    lockOwner_d = lockOwner_q;
    toCnt_d     = toCnt_q;

    if (!lockOn_q || !idle_i || ownerValid || expired) begin
      toCnt_d = '0;
    end else if (toCnt_q != TW'(LOCK_TO)) begin
      toCnt_d = toCnt_q + 1'b1;
    end

    if (expired) lockOn_d = 1'b0;

    // An accepted word overrides the timeout: it may re-lock immediately.
    if (|grant_o) begin
      lastGnt_d = winIdx;
      if (lock_i[winIdx]) begin
        lockOn_d    = 1'b1;
        lockOwner_d = winIdx;
      end else if (lockOn_q && (lockOwner_q == winIdx)) begin
        lockOn_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lastGnt_q   <= 1'b1;
      lockOn_q    <= 1'b0;
      lockOwner_q <= 1'b0;
      toCnt_q     <= '0;
    end else begin
      lastGnt_q   <= lastGnt_d;
      lockOn_q    <= lockOn_d;
      lockOwner_q <= lockOwner_d;
      toCnt_q     <= toCnt_d;
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares the single LCD1602 byte-write port between two requesters.
// Sequences each accepted word through ctrl_Start/ctrl_Done and enforces the
// inter-command hold-off before the next word may be accepted.
// Ports:
//   iCLK, iRST   clock, asynchronous active-high reset
//   bus          lcd_write_arbiter_if.slave (requesters, controller handshake,
//                oGRANT and oBUSY status)
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned DELAY_CYC = 32'(LCD_DELAY_DEFAULT),
  parameter int unsigned LOCK_TO   = 1024
) (
  input  logic               iCLK,
  input  logic               iRST,
  lcd_write_arbiter_if.slave bus
);

  localparam logic [1:0]  ST_IDLE      = IDLE;
  localparam logic [1:0]  ST_WAIT_DONE = WAIT_DONE;
  localparam logic [1:0]  ST_HOLDOFF   = HOLDOFF;
  localparam int unsigned HW = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;
  lcd_word_t     word_q, word_d;
  logic [1:0]    grant_q, grant_d;

  logic [1:0]    arbGrant;
  logic          accept;
  logic          isIdle;

  assign isIdle = (state_q == ST_IDLE);

  lcd_rr_arbiter #(
    .LOCK_TO (LOCK_TO)
  ) u_arb (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .idle_i  (isIdle),
    .valid_i ({bus.iREQ1_VALID, bus.iREQ0_VALID}),
    .lock_i  ({bus.iREQ1_LOCK, bus.iREQ0_LOCK}),
    .grant_o (arbGrant)
  );

  assign accept = |arbGrant;

  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.iCTRL_DONE) begin
          state_d   = ST_HOLDOFF;
          holdCnt_d = '0;
        end
      end
      ST_HOLDOFF: begin
        if (holdCnt_q == HW'(DELAY_CYC - 1)) state_d = ST_IDLE;
        else                                 holdCnt_d = holdCnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The word stays on the controller bus until the next accept.
  always_comb begin
    word_d  = word_q;
    grant_d = grant_q;
    if (accept) begin
      grant_d = arbGrant;
      word_d  = arbGrant[1] ? lcd_word_t'(bus.iREQ1_DATA) : lcd_word_t'(bus.iREQ0_DATA);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      holdCnt_q <= '0;
      word_q    <= '0;
      grant_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      word_q    <= word_d;
      grant_q   <= grant_d;
    end
  end

  // READY is masked during reset so every output reads 0 while iRST is high.
  assign bus.oREQ0_READY = arbGrant[0] && !iRST;
  assign bus.oREQ1_READY = arbGrant[1] && !iRST;
  assign bus.oCTRL_START = (state_q == ST_WAIT_DONE);
  assign bus.oCTRL_RS    = word_q.rs;
  assign bus.oCTRL_DATA  = word_q.data;
  assign bus.oGRANT      = grant_q;
  assign bus.oBUSY       = !isIdle;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Self-checking bench for lcd_write_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference
// model (timestamps for hold-off, an owner id for the lock).
module tb_lcd_write_arbiter;

  localparam int DELAY = 5;
  localparam int LOCKT = 7;

  logic clk;
  logic rst;

  lcd_write_arbiter_if bus();

  lcd_write_arbiter #(
    .DELAY_CYC (DELAY),
    .LOCK_TO   (LOCKT)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference model state.
  int       cycle     = 0;
  bit       mWaiting  = 0;
  int       mIdleAt   = 0;
  int       mOwner    = -1;
  int       mAbsent   = 0;
  int       mLast     = 1;
  bit [8:0] mWord     = '0;
  bit [1:0] mGrant    = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [8:0] d0, input logic l0,
                               input logic v1, input logic [8:0] d1, input logic l1,
                               input logic done);
    bus.iREQ0_VALID = v0;
    bus.iREQ0_DATA  = d0;
    bus.iREQ0_LOCK  = l0;
    bus.iREQ1_VALID = v1;
    bus.iREQ1_DATA  = d1;
    bus.iREQ1_LOCK  = l1;
    bus.iCTRL_DONE  = done;
  endtask

  function automatic bit modelIdle();
    return !mWaiting && (cycle >= mIdleAt);
  endfunction

  function automatic bit ownerValid();
    if (mOwner == 0) return bus.iREQ0_VALID;
    if (mOwner == 1) return bus.iREQ1_VALID;
    return 1'b0;
  endfunction

  // The owner forfeits its lock after LOCK_TO full idle cycles of absence.
  function automatic bit lockVoid();
    return (mOwner >= 0) && modelIdle() && !ownerValid() && (mAbsent >= LOCKT);
  endfunction

  function automatic int pickWinner();
    if (!modelIdle()) return -1;
    if ((mOwner >= 0) && !lockVoid()) return ownerValid() ? mOwner : -1;
    if (bus.iREQ0_VALID && bus.iREQ1_VALID) return 1 - mLast;
    if (bus.iREQ0_VALID) return 0;
    if (bus.iREQ1_VALID) return 1;
    return -1;
  endfunction

  task automatic modelReset();
    mWaiting = 0;
    mIdleAt  = cycle;
    mOwner   = -1;
    mAbsent  = 0;
    mLast    = 1;
    mWord    = '0;
    mGrant   = '0;
  endtask

  // Compare all outputs against the model, then let the model and DUT take one edge.
  task automatic runCycle();
    int  w;
    bit  idle;
    bit  lv;
    bit  ov;
    #1;
    w    = pickWinner();
    idle = modelIdle();
    lv   = lockVoid();
    ov   = ownerValid();
    checkOutput("ready0", bus.oREQ0_READY, (w == 0));
    checkOutput("ready1", bus.oREQ1_READY, (w == 1));
    checkOutput("start",  bus.oCTRL_START, mWaiting);
    checkOutput("busy",   bus.oBUSY,       !idle);
    checkOutput("grant",  bus.oGRANT,      mGrant);
    checkOutput("rs",     bus.oCTRL_RS,    mWord[8]);
    checkOutput("data",   bus.oCTRL_DATA,  mWord[7:0]);

    if (mWaiting && bus.iCTRL_DONE) begin
      mWaiting = 0;
      mIdleAt  = cycle + DELAY + 1;
    end
    if ((mOwner >= 0) && idle && !ov && !lv) mAbsent++;
    else                                     mAbsent = 0;
    if (lv) mOwner = -1;
    if (w >= 0) begin
      mWaiting = 1;
      mLast    = w;
      mGrant   = (w == 0) ? 2'b01 : 2'b10;
      mWord    = (w == 0) ? bus.iREQ0_DATA : bus.iREQ1_DATA;
      if ((w == 0) ? bus.iREQ0_LOCK : bus.iREQ1_LOCK) mOwner = w;
      else if (mOwner == w)                            mOwner = -1;
      mAbsent = 0;
    end
    cycle++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drainToIdle();
    for (int i = 0; i < 60; i++) begin
      if (modelIdle()) return;
      applyStimulus(0, 9'h0, 0, 0, 9'h0, 0, mWaiting);
      runCycle();
    end
    checkOutput("drainTimeout", 1, 0);
  endtask

  logic [8:0] words1 [3] = '{9'h0C0, 9'h141, 9'h142};
  bit         locks1 [3] = '{1'b1, 1'b1, 1'b0};
  int         probs  [5] = '{0, 10, 50, 90, 100};

  initial begin
    int seq[$];
    int span;
    int blocked;
    int idx;
    int p0;
    int p1;
    bit seen;

    rst = 1'b1;
    applyStimulus(1, 9'h1FF, 1, 1, 9'h1FF, 1, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rstReady0", bus.oREQ0_READY, 0);
    checkOutput("rstReady1", bus.oREQ1_READY, 0);
    checkOutput("rstStart",  bus.oCTRL_START, 0);
    checkOutput("rstBusy",   bus.oBUSY, 0);
    checkOutput("rstGrant",  bus.oGRANT, 0);
    checkOutput("rstData",   {bus.oCTRL_RS, bus.oCTRL_DATA}, 0);
    @(negedge clk);
    applyStimulus(0, 9'h0, 0, 0, 9'h0, 0, 0);
    rst = 1'b0;
    modelReset();

    // Single word from req0, then hold-off span to the next accept.
    applyStimulus(1, 9'h038, 0, 0, 9'h0, 0, 0);
    runCycle();
    checkOutput("firstStart", bus.oCTRL_START, 1);
    checkOutput("firstRs",    bus.oCTRL_RS, 0);
    checkOutput("firstData",  bus.oCTRL_DATA, 8'h38);
    checkOutput("firstGrant", bus.oGRANT, 2'b01);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 9'h0, 0, 0, 9'h0, 0, 0);
      runCycle();
    end
    applyStimulus(0, 9'h0, 0, 0, 9'h0, 0, 1);
    runCycle();
    checkOutput("startDrop", bus.oCTRL_START, 0);
    span = -1;
    for (int n = 1; n < 50; n++) begin
      applyStimulus(1, 9'h101, 0, 0, 9'h0, 0, 0);
      #1;
      if (bus.oREQ0_READY) begin
        span = n;
        break;
      end
      runCycle();
    end
    checkOutput("holdoffSpan", span, DELAY + 1);
    runCycle();
    drainToIdle();

    // Done pulses outside WAIT_DONE leave state and outputs alone.
    applyStimulus(0, 9'h0, 0, 0, 9'h0, 0, 1);
    runCycle();
    checkOutput("doneIdleBusy", bus.oBUSY, 0);
    checkOutput("doneIdleData", bus.oCTRL_DATA, 8'h01);

    // req1 locked burst while req0 keeps asking.
    idx = 0;
    seq.delete();
    for (int i = 0; i < 200 && seq.size() < 4; i++) begin
      applyStimulus(1, 9'h0AA, 0, (idx < 3), words1[idx < 3 ? idx : 2], locks1[idx < 3 ? idx : 2], mWaiting);
      #1;
      if (bus.oREQ0_READY) seq.push_back(0);
      if (bus.oREQ1_READY) begin
        seq.push_back(1);
        idx++;
      end
      runCycle();
    end
    checkOutput("burstLen", seq.size(), 4);
    for (int i = 0; i < 4 && i < seq.size(); i++)
      checkOutput("burstOrder", seq[i], (i < 3) ? 1 : 0);
    drainToIdle();

    // req0 locks then goes away; req1 must wait LOCK_TO idle cycles.
    applyStimulus(1, 9'h080, 1, 0, 9'h0, 0, 0);
    runCycle();
    blocked = 0;
    seen    = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, 9'h0, 0, 1, 9'h155, 0, mWaiting);
      #1;
      if (bus.oREQ1_READY) begin
        seen = 1;
        break;
      end
      if (!bus.oBUSY) blocked++;
      runCycle();
    end
    checkOutput("timeoutSeen", seen, 1);
    checkOutput("lockTimeout", blocked, LOCKT);
    runCycle();
    applyStimulus(0, 9'h0, 0, 0, 9'h0, 0, 1);
    runCycle();
    applyStimulus(0, 9'h0, 0, 0, 9'h0, 0, 1);
    runCycle();
    checkOutput("doneHoldBusy",  bus.oBUSY, 1);
    checkOutput("doneHoldStart", bus.oCTRL_START, 0);
    drainToIdle();

    // req1 takes a lock, reset lands mid-transfer, first tie goes to req0.
    applyStimulus(0, 9'h0, 0, 1, 9'h1C5, 1, 0);
    runCycle();
    applyStimulus(1, 9'h011, 0, 1, 9'h022, 0, 0);
    rst = 1'b1;
    #1;
    checkOutput("midRstStart",  bus.oCTRL_START, 0);
    checkOutput("midRstBusy",   bus.oBUSY, 0);
    checkOutput("midRstGrant",  bus.oGRANT, 0);
    checkOutput("midRstReady0", bus.oREQ0_READY, 0);
    checkOutput("midRstReady1", bus.oREQ1_READY, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    seq.delete();
    for (int i = 0; i < 100 && seq.size() < 4; i++) begin
      applyStimulus(1, 9'h011, 0, 1, 9'h022, 0, mWaiting);
      #1;
      if (bus.oREQ0_READY) seq.push_back(0);
      if (bus.oREQ1_READY) seq.push_back(1);
      runCycle();
    end
    checkOutput("altLen", seq.size(), 4);
    for (int i = 0; i < 4 && i < seq.size(); i++)
      checkOutput("altOrder", seq[i], i % 2);
    drainToIdle();

    // Randomized traffic in epochs of varying request density.
    for (int e = 0; e < 50; e++) begin
      p0 = probs[$urandom_range(4)];
      p1 = probs[$urandom_range(4)];
      for (int c = 0; c < 30; c++) begin
        applyStimulus($urandom_range(99) < p0, 9'($urandom), $urandom_range(99) < 30,
                      $urandom_range(99) < p1, 9'($urandom), $urandom_range(99) < 30,
                      $urandom_range(99) < 40);
        runCycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
